// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the 8-bit CPU bus.
// Decodes 0x00..RAM_TOP as on-chip RAM and 0xF0..0xF6 as memory-mapped I/O:
// GPIO_OUT, synchronised GPIO_IN, STATUS, TX/RX byte FIFOs and a timer.
// The timer exists only when MEMIO_TIMER_EN is defined; otherwise TIMER and
// TIMER_CTRL read as 0x00, writes to them are ignored and STATUS b4 stays 0.
module mem_io_responder #(
  parameter logic [7:0]  RAM_TOP    = 8'hEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  GPIO_RST   = 8'h00,
  parameter int unsigned TIMER_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] address,
  input  logic [7:0] dout,
  output logic [7:0] din,
  output logic [7:0] gpio_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [7:0] A_GPIO_OUT = 8'hF0;
  localparam logic [7:0] A_GPIO_IN  = 8'hF1;
  localparam logic [7:0] A_STATUS   = 8'hF2;
  localparam logic [7:0] A_TX_DATA  = 8'hF3;
  localparam logic [7:0] A_RX_DATA  = 8'hF4;
  localparam logic [7:0] A_TIMER    = 8'hF5;
  localparam logic [7:0] A_TCTRL    = 8'hF6;

  // Storage arrays
  logic [7:0] ram_q    [0:RAM_TOP];
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];

  // Control state
  logic [7:0]    gpio_out_q, sync1_q, sync2_q;
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          ovf_q, ovf_d;

  // Decoded strobes; a simultaneous write suppresses the read side effect
  logic wr_ram, wr_gpio, wr_status, wr_tx, rd_rx;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_drop, tx_pop, rx_push, rx_pop;
  logic sts_wrap;
  logic [7:0] timer_rd, tctrl_rd, status;

  assign wr_ram    = write && (address <= RAM_TOP);
  assign wr_gpio   = write && (address == A_GPIO_OUT);
  assign wr_status = write && (address == A_STATUS);
  assign wr_tx     = write && (address == A_TX_DATA);
  assign rd_rx     = read && !write && (address == A_RX_DATA);

  assign tx_full  = (tx_cnt_q == DEPTH_C);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DEPTH_C);
  assign rx_empty = (rx_cnt_q == '0);

  // Fullness is judged at cycle start, so a same-cycle pop does not make room
  assign tx_push = wr_tx && !tx_full;
  assign tx_drop = wr_tx && tx_full;
  assign tx_pop  = !tx_empty && tx_ready;
  assign rx_push = rx_valid && !rx_full;
  assign rx_pop  = rd_rx && !rx_empty;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem_q[tx_rp_q];
  assign rx_ready = !rx_full;
  assign gpio_out = gpio_out_q;

  assign status = {2'b00, ovf_q, sts_wrap, rx_full, rx_empty, tx_empty, tx_full};

  // Next-state logic for FIFO pointers, counts and the overflow sticky bit
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    tx_wp_d  = tx_wp_q + PW'(tx_push);
    tx_rp_d  = tx_rp_q + PW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d  = rx_wp_q + PW'(rx_push);
    rx_rp_d  = rx_rp_q + PW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    ovf_d    = (ovf_q && !(wr_status && dout[5])) || tx_drop;
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      gpio_out_q <= GPIO_RST;
      sync1_q    <= '0;
      sync2_q    <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_gpio) gpio_out_q <= dout;
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // RAM and FIFO storage writes
  always_ff @(posedge clk) begin
    // NOTE: storage arrays have no reset; RAM must persist across rst and FIFO contents are invalidated by the pointers.
    if (wr_ram)  ram_q[address]     <= dout;
    if (tx_push) tx_mem_q[tx_wp_q]  <= dout;
    if (rx_push) rx_mem_q[rx_wp_q]  <= rx_data;
  end

`ifdef MEMIO_TIMER_EN
  localparam int unsigned  DW       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TIMER_DIV - 1);

  logic [7:0]    timer_q, timer_d, tctrl_q, tctrl_d;
  logic [DW-1:0] presc_q, presc_d;
  logic          wrap_q, wrap_d, tick, wrap_set, wr_timer, wr_tctrl;

  assign wr_timer = write && (address == A_TIMER);
  assign wr_tctrl = write && (address == A_TCTRL);
  assign tick     = tctrl_q[0] && (presc_q == DIV_LAST);

  // Timer next state; a CPU load beats a tick and restarts the prescaler
  always_comb begin
    timer_d  = timer_q;
    tctrl_d  = tctrl_q;
    presc_d  = presc_q;
    wrap_set = 1'b0;
    if (tctrl_q[0]) presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick) begin
      timer_d  = timer_q + 8'd1;
      wrap_set = (timer_q == 8'hFF);
    end
    if (wr_timer) begin
      timer_d  = dout;
      presc_d  = '0;
      wrap_set = 1'b0;
    end
    if (wr_tctrl) tctrl_d = dout;
    wrap_d = (wrap_q && !(wr_status && dout[4])) || wrap_set;
  end

  // Timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      tctrl_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tctrl_q <= tctrl_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign timer_rd = timer_q;
  assign tctrl_rd = tctrl_q;
  assign sts_wrap = wrap_q;
`else
  assign timer_rd = 8'h00;
  assign tctrl_rd = 8'h00;
  assign sts_wrap = 1'b0;
`endif

  // Combinational read mux; 0x00 when idle or unmapped
  always_comb begin
    din = 8'h00;
    if (read) begin
      if (address <= RAM_TOP) begin
        din = ram_q[address];
      end else begin
        case (address)
          A_GPIO_OUT: din = gpio_out_q;
          A_GPIO_IN:  din = sync2_q;
          A_STATUS:   din = status;
          A_RX_DATA:  din = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
          A_TIMER:    din = timer_rd;
          A_TCTRL:    din = tctrl_rd;
          default:    din = 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: stimulus pushes expected read data
// and expected TX bytes into queues; a negedge monitor pops and compares.
module tb_mem_io_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write = 1'b0, read = 1'b0;
  logic [7:0] address = '0, dout = '0, din;
  logic [7:0] gpio_out, gpio_in = '0;
  logic [7:0] tx_data, rx_data = '0;
  logic       tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  mem_io_responder #(.GPIO_RST(8'h3C)) dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .dout(dout), .din(din), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares din on read cycles and tx_data on TX handshakes
  always @(negedge clk) begin
    if (read) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: read of 0x%0h with no expected value queued", address);
      end else begin
        check($sformatf("rd@%0h", address), 32'(din), 32'(exp_rd.pop_front()));
      end
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got 0x%0h with no byte queued", tx_data);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    write = 1'b1; address = a; dout = d;
    cycle();
    write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    read = 1'b1; address = a;
    exp_rd.push_back(e);
    cycle();
    read = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held
    #12;
    check("rst_gpio_out", 32'(gpio_out), 32'h3C);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    #5 rst = 1'b1;
    cycle();
    check("din_idle", 32'(din), 32'h00);
    rd(8'hF2, 8'h06);                       // tx_empty + rx_empty

    // RAM, boundary and unmapped addresses
    wr(8'h10, 8'h5A);
    rd(8'h10, 8'h5A);
    rd(8'hF8, 8'h00);
    wr(8'hEF, 8'h77);
    rd(8'hEF, 8'h77);
    wr(8'hF7, 8'h99);
    rd(8'hF7, 8'h00);

    // GPIO_OUT
    wr(8'hF0, 8'hA5);
    check("gpio_out", 32'(gpio_out), 32'hA5);
    rd(8'hF0, 8'hA5);

    // TX: fill past capacity with the consumer stalled
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) wr(8'hF3, 8'(i));
    check("tx_valid_full", 32'(tx_valid), 32'h1);
    check("tx_head", 32'(tx_data), 32'h01);
    rd(8'hF2, 8'h25);                       // full + overflow, RX still empty
    for (int i = 1; i <= 4; i++) exp_tx.push_back(8'(i));
    tx_ready = 1'b1;
    idle(6);
    tx_ready = 1'b0;
    check("tx_drained", 32'(tx_valid), 32'h0);
    check("tx_exp_left", 32'(exp_tx.size()), 32'h0);
    rd(8'hF2, 8'h26);
    wr(8'hF2, 8'h20);
    rd(8'hF2, 8'h06);

    // TX: push to a full FIFO is dropped even while the head pops
    for (int i = 0; i < 4; i++) begin
      wr(8'hF3, 8'hB0 + 8'(i));
      exp_tx.push_back(8'hB0 + 8'(i));
    end
    tx_ready = 1'b1;
    wr(8'hF3, 8'hB4);
    idle(4);
    tx_ready = 1'b0;
    rd(8'hF2, 8'h26);
    wr(8'hF2, 8'h20);

    // RX: fill, one ignored byte while full, then drain
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'hA0 + 8'(i);
      cycle();
    end
    rx_data = 8'hA4;
    cycle();
    rx_valid = 1'b0;
    check("rx_ready_full", 32'(rx_ready), 32'h0);
    rd(8'hF2, 8'h0A);                       // tx_empty + rx_full
    for (int i = 0; i < 4; i++) rd(8'hF4, 8'hA0 + 8'(i));
    rd(8'hF2, 8'h06);
    rd(8'hF4, 8'h00);

    // RX: write+read suppresses the pop; push and pop in one cycle
    rx_valid = 1'b1; rx_data = 8'hC5;
    cycle();
    rx_valid = 1'b0;
    write = 1'b1; read = 1'b1; address = 8'hF4; dout = 8'h11;
    exp_rd.push_back(8'hC5);
    cycle();
    write = 1'b0; read = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hD1;
    rd(8'hF4, 8'hC5);
    rx_valid = 1'b0;
    rd(8'hF4, 8'hD1);
    rd(8'hF4, 8'h00);

    // GPIO_IN two-flop synchroniser
    idle(2);
    gpio_in = 8'hC3;
    cycle();
    rd(8'hF1, 8'h00);
    rd(8'hF1, 8'hC3);

`ifdef MEMIO_TIMER_EN
    // Timer: 0xFE, enabled, 16-cycle tick
    wr(8'hF5, 8'hFE);
    wr(8'hF6, 8'h01);
    idle(15);
    rd(8'hF5, 8'hFE);
    rd(8'hF5, 8'hFF);
    idle(14);
    rd(8'hF5, 8'hFF);
    rd(8'hF5, 8'h00);
    rd(8'hF2, 8'h16);
    wr(8'hF2, 8'h10);
    rd(8'hF2, 8'h06);
    wr(8'hF6, 8'h00);
`else
    wr(8'hF5, 8'h42);
    wr(8'hF6, 8'h01);
    rd(8'hF5, 8'h00);
    rd(8'hF6, 8'h00);
`endif

    // Asynchronous reset mid-cycle with both FIFOs holding data
    wr(8'hF3, 8'hEE);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
    rx_valid = 1'b1; rx_data = 8'h55;
    idle(4);
    rx_valid = 1'b0;
    check("pre_rst_rx_ready", 32'(rx_ready), 32'h0);
    #3 rst = 1'b0;
    #1;
    check("async_gpio_out", 32'(gpio_out), 32'h3C);
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    check("async_rx_ready", 32'(rx_ready), 32'h1);
    #2 rst = 1'b1;
    cycle();
    rd(8'hF2, 8'h06);
    rd(8'hF0, 8'h3C);
    rd(8'h10, 8'h5A);                       // RAM survives reset
    rd(8'hF4, 8'h00);

    idle(2);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
